// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared segment state encoding and length lookup for the video timing axes
package vga_timing_pkg;

  typedef logic [1:0] seg_state_t;

  localparam seg_state_t SEG_SYNC   = 2'b00;
  localparam seg_state_t SEG_BP     = 2'b01;
  localparam seg_state_t SEG_ACTIVE = 2'b10;
  localparam seg_state_t SEG_FP     = 2'b11;

  // Length of the segment a given state occupies on one axis.
  function automatic int unsigned seg_len(
    input seg_state_t  s,
    input int unsigned l_sync,
    input int unsigned l_bp,
    input int unsigned l_active,
    input int unsigned l_fp
  );
    int unsigned len;
    len = l_sync;
    case (s)
      SEG_BP:     len = l_bp;
      SEG_ACTIVE: len = l_active;
      SEG_FP:     len = l_fp;
      default:    len = l_sync;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// rtl/vga_timing_gen_axis.sv - one timing axis: SYNC/BP/ACTIVE/FP state with a per-segment counter
module timing_axis
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W    = 11,
  parameter int unsigned L_SYNC   = 1,
  parameter int unsigned L_BP     = 1,
  parameter int unsigned L_ACTIVE = 1,
  parameter int unsigned L_FP     = 1
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             adv,
  output seg_state_t       state,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  // Zero-length segments would never terminate; oversize ones would wrap the counter.
  if (L_SYNC == 0 || L_BP == 0 || L_ACTIVE == 0 || L_FP == 0) begin : g_zero_len
    $error("timing_axis: segment length of zero is not allowed");
  end
  if (64'(L_SYNC) > (64'd1 << CNT_W) || 64'(L_BP) > (64'd1 << CNT_W) ||
      64'(L_ACTIVE) > (64'd1 << CNT_W) || 64'(L_FP) > (64'd1 << CNT_W)) begin : g_long_len
    $error("timing_axis: segment length exceeds counter range");
  end

  logic [CNT_W-1:0] last_cnt;

  // Final count value of the current segment, truncated to counter width (LEN <= 2**CNT_W keeps it exact).
  always_comb begin
    last_cnt = CNT_W'(seg_len(state, L_SYNC, L_BP, L_ACTIVE, L_FP) - 32'd1);
  end

  // Terminal strobe is suppressed during reset so nothing downstream advances off stale state.
  assign term = ~reset & adv & (cnt == last_cnt);

  // Count within the segment; on the last count move to the next segment (2-bit wrap gives FP->SYNC).
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= SEG_SYNC;
      cnt   <= '0;
    end else if (adv) begin
      if (cnt == last_cnt) begin
        state <= state + 2'd1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised video timing generator with sync, data enable, coordinates and strobes
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W     = 11,
  parameter int unsigned H_SYNC    = 128,
  parameter int unsigned H_BP      = 88,
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 40,
  parameter int unsigned V_SYNC    = 4,
  parameter int unsigned V_BP      = 23,
  parameter int unsigned V_ACTIVE  = 600,
  parameter int unsigned V_FP      = 1,
  parameter bit          HSYNC_POL = 1'b1,
  parameter bit          VSYNC_POL = 1'b1
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_end,
  output logic             frame_end
);

  seg_state_t       h_state;
  seg_state_t       v_state;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_term;
  logic             v_term;

  timing_axis #(
    .CNT_W   (CNT_W),
    .L_SYNC  (H_SYNC),
    .L_BP    (H_BP),
    .L_ACTIVE(H_ACTIVE),
    .L_FP    (H_FP)
  ) u_h_axis (
    .sys_clk(sys_clk),
    .reset  (reset),
    .adv    (pix_ce),
    .state  (h_state),
    .cnt    (h_cnt),
    .term   (h_term)
  );

  // Vertical axis counts lines, so it advances once per completed line.
  timing_axis #(
    .CNT_W   (CNT_W),
    .L_SYNC  (V_SYNC),
    .L_BP    (V_BP),
    .L_ACTIVE(V_ACTIVE),
    .L_FP    (V_FP)
  ) u_v_axis (
    .sys_clk(sys_clk),
    .reset  (reset),
    .adv    (line_end),
    .state  (v_state),
    .cnt    (v_cnt),
    .term   (v_term)
  );

  // Strobes: terms already carry pix_ce and reset gating, so only the segment needs qualifying.
  always_comb begin
    line_end  = h_term & (h_state == SEG_FP);
    frame_end = v_term & (v_state == SEG_FP);
  end

  // Video outputs decode registered state only, so they move solely on enabled edges.
  always_comb begin
    hsync = (h_state == SEG_SYNC) ? HSYNC_POL : ~HSYNC_POL;
    vsync = (v_state == SEG_SYNC) ? VSYNC_POL : ~VSYNC_POL;
    de    = (h_state == SEG_ACTIVE) && (v_state == SEG_ACTIVE);
    x     = (h_state == SEG_ACTIVE) ? h_cnt : '0;
    y     = (v_state == SEG_ACTIVE) ? v_cnt : '0;
  end

endmodule
